// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_seq_pkg
// Brief   : Shared types and default sizes for the multi-precision
//           add/subtract sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Default slice width and number of words per operand
  localparam int ADD_N     = 32;
  localparam int ADD_WORDS = 4;

endpackage : adder_seq_pkg
`default_nettype wire

// File: rtl/full_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module  : full_adder_nbit
// Brief   : Purely combinational N-bit adder slice with carry in / carry out.
// Revision: 1.0 - initial release
// ============================================================================
module full_adder_nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  // One extra bit on the left collects the carry out of the slice
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};

endmodule : full_adder_nbit
`default_nettype wire

// File: rtl/adder_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : adder_word_sequencer
// Brief   : Multi-precision add/subtract controller. Streams WORDS slices of
//           N bits, least significant first, through one shared adder and
//           keeps the inter-word carry in a register.
// Revision: 1.0 - initial release
// ============================================================================
module adder_word_sequencer
  import adder_seq_pkg::*;
#(
  parameter int N     = ADD_N,
  parameter int WORDS = ADD_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   result,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  seq_state_t     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  // Operands viewed as word arrays so the slice can be picked by idx
  logic [N-1:0]   a_word [WORDS];
  logic [N-1:0]   b_word [WORDS];
  logic [N-1:0]   slice_sum;
  logic           slice_cout;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
    assign a_word[gi] = a_q[gi*N +: N];
    assign b_word[gi] = b_q[gi*N +: N];
  end

  full_adder_nbit #(
    .N (N)
  ) u_slice (
    .A    (a_word[idx_q]),
    .B    (b_word[idx_q]),
    .Cin  (carry_q),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  // State, counter, carry and data registers; reset drops any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: accept, word-by-word accumulate, hold until handshake
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1; the +1 enters as the first carry
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == IW'(w)) begin
            result_d[w*N +: N] = slice_sum;
          end
        end
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          // Signed overflow: like-signed operands give a differently signed sum
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[N-1] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule : adder_word_sequencer
`default_nettype wire

// File: tb/tb_adder_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder_word_sequencer
// Brief   : Scoreboard bench: the driver pushes golden results on accept, a
//           monitor pops and compares whenever a result is presented.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adder_word_sequencer;

  localparam int N     = 32;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  adder_word_sequencer #(
    .N     (N),
    .WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Golden model from integer arithmetic on sign/zero-extended operands
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic sub, input int acc);
    exp_t        e;
    logic [W:0]  u;
    logic [W:0]  s;
    if (sub) begin
      u    = {1'b0, ma} - {1'b0, mb};
      s    = {ma[W-1], ma} - {mb[W-1], mb};
      e.co = (ma >= mb);
    end else begin
      u    = {1'b0, ma} + {1'b0, mb};
      s    = {ma[W-1], ma} + {mb[W-1], mb};
      e.co = u[W];
    end
    e.res = u[W-1:0];
    e.ov  = (s[W] != s[W-1]);
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Consumer readiness
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every presented result against the scoreboard head
  initial begin
    bit   prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          chk("in_ready_in_done", {{(W-1){1'b0}}, in_ready}, '0);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got out_valid=1 expected no pending op");
          end else begin
            e = exp_q[0];
            if (!prev_v) chk("latency", W'(cyc), W'(e.acc + WORDS));
            chk("result", result, e.res);
            chk("carry_out", {{(W-1){1'b0}}, carry_out}, {{(W-1){1'b0}}, e.co});
            chk("overflow", {{(W-1){1'b0}}, overflow}, {{(W-1){1'b0}}, e.ov});
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_v = out_valid;
      end
    end
  end

  // Present one request and hold it until accepted; called at posedge+1
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
    int t;
    t = 0;
    a = ta; b = tb_v; op_sub = ts; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(ta, tb_v, ts, cyc + 1));
        break;
      end
      t++;
      if (t > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = rnd128(); b = rnd128(); op_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_pending", W'(exp_q.size()), '0);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    int           t;
    ones = '1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    chk("rst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    chk("rst_result", result, '0);
    chk("rst_carry", {{(W-1){1'b0}}, carry_out}, '0);
    chk("rst_overflow", {{(W-1){1'b0}}, overflow}, '0);
    rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Directed corner cases
    do_op(ones, W'(1), 1'b0);                              drain();
    do_op('0, W'(1), 1'b1);                                drain();
    do_op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);             drain();
    do_op({32'h0, {96{1'b1}}}, W'(1), 1'b0);               drain();
    do_op({1'b1, {(W-1){1'b0}}}, W'(1), 1'b1);             drain();

    // Backpressure: result held, requests refused
    ready_mode = 2;
    do_op(rnd128(), rnd128(), 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = rnd128(); b = rnd128();
      @(negedge clk);
      chk("bp_in_ready", {{(W-1){1'b0}}, in_ready}, '0);
      chk("bp_out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ready_mode = 0;
    drain();

    // Reset in the middle of an operation (after two words)
    xa = rnd128() | W'(1);
    xb = rnd128();
    do_op(xa, xb, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    chk("midrst_result", result, '0);
    chk("midrst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    chk("midrst_carry", {{(W-1){1'b0}}, carry_out}, '0);
    chk("midrst_overflow", {{(W-1){1'b0}}, overflow}, '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(xa, xb, 1'b1);
    drain();

    // Randomized traffic with random gaps and consumer stalls
    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 7))
        0:       xa = ones;
        1:       xa = '0;
        2:       xa = {1'b0, {(W-1){1'b1}}};
        3:       xa = {1'b1, {(W-1){1'b0}}};
        default: xa = rnd128();
      endcase
      xb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : rnd128();
      do_op(xa, xb, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_adder_word_sequencer
`default_nettype wire
